// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration slave.
package i2c_cfg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } i2c_cfg_state_e;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_RELEASE = 1'b1;
  localparam logic I2C_RD      = 1'b1;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_cfg_line_sync.sv
// Synchronises SCL/SDA and derives START, STOP and SCL edge pulses.
// Define I2C_CFG_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter (+2 cycles).
module i2c_cfg_line_sync
  import i2c_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic start_o,
  output logic stop_o,
  output logic scl_rise_o,
  output logic scl_fall_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_line, sda_line;
  logic                   scl_prev_q, sda_prev_q;

  // Reset to the idle-bus level so that leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

`ifdef I2C_CFG_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
      scl_filt_q <= maj3({scl_hist_q, scl_sync_q[SYNC_STAGES-1]});
      sda_filt_q <= maj3({sda_hist_q, sda_sync_q[SYNC_STAGES-1]});
    end
  end

  assign scl_line = scl_filt_q;
  assign sda_line = sda_filt_q;
`else
  assign scl_line = scl_sync_q[SYNC_STAGES-1];
  assign sda_line = sda_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_line;
      sda_prev_q <= sda_line;
    end
  end

  assign sda_o      = sda_line;
  assign scl_rise_o = scl_line & ~scl_prev_q;
  assign scl_fall_o = ~scl_line & scl_prev_q;
  assign start_o    = scl_line & scl_prev_q & sda_prev_q & ~sda_line;
  assign stop_o     = scl_line & scl_prev_q & ~sda_prev_q & sda_line;

endmodule

// File: rtl/i2c_cfg_slave.sv
// I2C register bridge: pointer byte with auto-increment, shadowed writes committed at STOP,
// coherent snapshot of read-only inputs. I2C_CFG_SLAVE_GLITCH_FILTER_EN enables input filtering.
module i2c_cfg_slave
  import i2c_cfg_pkg::*;
#(
  parameter int         NUM_OUT_REGS = 12,
  parameter int         NUM_IN_REGS  = 4,
  parameter logic [6:0] DEV_ADDR     = 7'h3C,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_o,
  input  logic [8*NUM_OUT_REGS-1:0] defaults,
  output logic [8*NUM_OUT_REGS-1:0] outputs,
  input  logic [8*NUM_IN_REGS-1:0]  inputs,
  output logic                      commit,
  output logic                      busy
);

  localparam int         TOTAL   = NUM_OUT_REGS + NUM_IN_REGS;
  localparam logic [8:0] TOTAL_W = 9'(TOTAL);

  typedef logic [NUM_OUT_REGS-1:0][7:0] out_regs_t;
  typedef logic [NUM_IN_REGS-1:0][7:0]  in_regs_t;

  i2c_cfg_state_e state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [6:0]     rx_q, rx_d;
  logic [7:0]     ptr_q, ptr_d;
  logic [7:0]     ptr_inc, rx_byte, rd_byte;
  logic           rw_q, rw_d;
  logic           dirty_q, dirty_d;
  logic           busy_q, busy_d;
  logic           commit_q, commit_d;
  logic           sda_q, sda_d;
  logic           fall_dly_q;
  out_regs_t      shadow_q, shadow_d;
  out_regs_t      outputs_q, outputs_d;
  in_regs_t       snap_q, snap_d;

  logic start, stop, scl_rise, scl_fall, sda_lvl;

  i2c_cfg_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .rstn      (rstn),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_o     (sda_lvl),
    .start_o   (start),
    .stop_o    (stop),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall)
  );

  assign rx_byte = {rx_q, sda_lvl};
  assign ptr_inc = ({1'b0, ptr_q} >= TOTAL_W - 9'd1) ? 8'd0 : ptr_q + 8'd1;

  // Out-of-range pointers (only reachable after a NACKed pointer) read as 0xFF.
  always_comb begin
    rd_byte = 8'hFF;
    for (int k = 0; k < NUM_OUT_REGS; k++)
      if ({1'b0, ptr_q} == 9'(k)) rd_byte = shadow_q[k];
    for (int k = 0; k < NUM_IN_REGS; k++)
      if ({1'b0, ptr_q} == 9'(NUM_OUT_REGS + k)) rd_byte = snap_q[k];
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    dirty_d   = dirty_q;
    busy_d    = busy_q;
    commit_d  = 1'b0;
    sda_d     = sda_q;
    shadow_d  = shadow_q;
    outputs_d = outputs_q;
    snap_d    = snap_q;

    if (start) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      busy_d    = 1'b1;
    end else if (stop) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      if (dirty_q) begin
        outputs_d = shadow_q;
        commit_d  = 1'b1;
        dirty_d   = 1'b0;
      end
    end else if (scl_rise) begin
      rx_d = rx_byte[6:0];
      unique case (state_q)
        ADDR: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (rx_byte[7:1] == DEV_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = rx_byte[0];
            end else begin
              state_d = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (rw_q == I2C_RD) begin
            snap_d  = inputs;
            state_d = RDATA;
          end else begin
            state_d = PTR;
          end
        end
        PTR: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ptr_d   = rx_byte;
            state_d = ({1'b0, rx_byte} < TOTAL_W) ? PTR_ACK : IDLE;
          end
        end
        PTR_ACK:   state_d = WDATA;
        WDATA: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            for (int k = 0; k < NUM_OUT_REGS; k++) begin
              if ({1'b0, ptr_q} == 9'(k)) begin
                shadow_d[k] = rx_byte;
                dirty_d     = 1'b1;
              end
            end
            ptr_d   = ptr_inc;
            state_d = WDATA_ACK;
          end
        end
        WDATA_ACK: state_d = WDATA;
        RDATA: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RDATA_ACK;
        end
        RDATA_ACK: begin
          if (sda_lvl == I2C_ACK) begin
            ptr_d   = ptr_inc;
            state_d = RDATA;
          end else begin
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end

    // SDA only moves one cycle after SCL is seen low, giving the master hold time.
    if (fall_dly_q) begin
      unique case (state_q)
        ADDR_ACK, PTR_ACK, WDATA_ACK: sda_d = I2C_ACK;
        RDATA:                        sda_d = rd_byte[3'd7 - bit_cnt_q];
        default:                      sda_d = I2C_RELEASE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      rx_q       <= '0;
      ptr_q      <= 8'd0;
      rw_q       <= 1'b0;
      dirty_q    <= 1'b0;
      busy_q     <= 1'b0;
      commit_q   <= 1'b0;
      sda_q      <= I2C_RELEASE;
      fall_dly_q <= 1'b0;
      // NOTE: the register file is reset on purpose; its reset values come from the defaults port.
      shadow_q   <= defaults;
      outputs_q  <= defaults;
      snap_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      dirty_q    <= dirty_d;
      busy_q     <= busy_d;
      commit_q   <= commit_d;
      sda_q      <= sda_d;
      fall_dly_q <= scl_fall;
      shadow_q   <= shadow_d;
      outputs_q  <= outputs_d;
      snap_q     <= snap_d;
    end
  end

  assign sda_o   = sda_q;
  assign outputs = outputs_q;
  assign commit  = commit_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_cfg_slave.sv
// Directed bench for i2c_cfg_slave: bit-banged I2C master, read-data scoreboard, register model.
module tb_i2c_cfg_slave;

  localparam int H = 100;  // quarter SCL period in ns; SCL = 2.5 MHz against a 100 MHz clk

  logic             clk = 1'b0;
  logic             rstn;
  logic             scl_m, sda_m;
  logic             sda_o_w, commit_w, busy_w;
  wire              sda_bus;
  logic [11:0][7:0] defaults_v, model, outputs_w;
  logic [3:0][7:0]  inputs_v;
  logic [7:0]       exp_q[$];
  int               n_checks = 0;
  int               n_pass = 0;
  int               commit_cnt = 0;
  int               commit_ref;

  assign sda_bus = sda_m & sda_o_w;

  i2c_cfg_slave dut (
    .clk     (clk),
    .rstn    (rstn),
    .scl_i   (scl_m),
    .sda_i   (sda_bus),
    .sda_o   (sda_o_w),
    .defaults(defaults_v),
    .outputs (outputs_w),
    .inputs  (inputs_v),
    .commit  (commit_w),
    .busy    (busy_w)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (commit_w === 1'b1) commit_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic v, output logic s);
    #(H); sda_m = v;
    #(H); scl_m = 1'b1;
    #(H); s = sda_bus;
    #(H); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    #(H); sda_m = 1'b1;
    #(H); scl_m = 1'b1;
    #(H); sda_m = 1'b0;
    #(H); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    #(H); sda_m = 1'b0;
    #(H); scl_m = 1'b1;
    #(H); sda_m = 1'b1;
    #(H);
  endtask

  task automatic wr(input logic [7:0] b, input logic exp_ack, input string tag);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, s);
    check(tag, {95'b0, ~s}, {95'b0, exp_ack});
  endtask

  task automatic rd(input logic master_ack, input string tag);
    logic       s;
    logic [7:0] b;
    logic [7:0] exp;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      b[i] = s;
    end
    bit_cycle(~master_ack, s);
    exp = exp_q.pop_front();
    check(tag, {88'b0, b}, {88'b0, exp});
  endtask

  initial begin
    for (int k = 0; k < 12; k++) defaults_v[k] = 8'h2E ^ 8'(k * 12);
    inputs_v = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    model    = defaults_v;
    scl_m    = 1'b1;
    sda_m    = 1'b1;
    rstn     = 1'b0;
    idle(5);
    rstn = 1'b1;
    idle(3);

    check("reset_outputs", outputs_w, model);
    check("reset_sda", {95'b0, sda_o_w}, 96'd1);
    check("reset_busy", {95'b0, busy_w}, 96'd0);
    check("reset_commit", {95'b0, commit_w}, 96'd0);

    // Read register 0 after reset.
    i2c_start();
    check("busy_after_start", {95'b0, busy_w}, 96'd1);
    wr(8'h78, 1'b1, "rd0_addr_w");
    wr(8'h00, 1'b1, "rd0_ptr");
    i2c_start();
    wr(8'h79, 1'b1, "rd0_addr_r");
    exp_q.push_back(model[0]);
    rd(1'b0, "rd0_data");
    i2c_stop();
    idle(4);
    check("rd0_busy_after_stop", {95'b0, busy_w}, 96'd0);
    check("rd0_no_commit", 96'(commit_cnt), 96'd0);

    // Two-byte write committed at STOP.
    i2c_start();
    wr(8'h78, 1'b1, "wr2_addr");
    wr(8'h02, 1'b1, "wr2_ptr");
    wr(8'hA5, 1'b1, "wr2_d0");
    wr(8'h5A, 1'b1, "wr2_d1");
    check("wr2_outputs_before_stop", outputs_w, model);
    check("wr2_no_commit_before_stop", 96'(commit_cnt), 96'd0);
    i2c_stop();
    idle(4);
    model[2] = 8'hA5;
    model[3] = 8'h5A;
    check("wr2_commit_once", 96'(commit_cnt), 96'd1);
    check("wr2_outputs", outputs_w, model);

    // Out-of-range pointer is NACKed and nothing commits.
    commit_ref = commit_cnt;
    i2c_start();
    wr(8'h78, 1'b1, "badptr_addr");
    wr(8'h10, 1'b0, "badptr_nack");
    i2c_stop();
    idle(4);
    check("badptr_no_commit", 96'(commit_cnt), 96'(commit_ref));

    // Writes crossing into the read-only range are discarded but ACKed.
    i2c_start();
    wr(8'h78, 1'b1, "ro_addr");
    wr(8'h0B, 1'b1, "ro_ptr");
    wr(8'h77, 1'b1, "ro_d11");
    wr(8'h66, 1'b1, "ro_d12_discard");
    i2c_stop();
    idle(4);
    model[11] = 8'h77;
    check("ro_outputs", outputs_w, model);

    // Pointer wraps from 15 back to 0.
    i2c_start();
    wr(8'h78, 1'b1, "wrap_addr");
    wr(8'h0F, 1'b1, "wrap_ptr");
    wr(8'h11, 1'b1, "wrap_d15");
    wr(8'h99, 1'b1, "wrap_d0");
    i2c_stop();
    idle(4);
    model[0] = 8'h99;
    check("wrap_outputs", outputs_w, model);

    // Snapshot read across the RO range; inputs change after the address ACK.
    i2c_start();
    wr(8'h78, 1'b1, "snap_addr_w");
    wr(8'h0C, 1'b1, "snap_ptr");
    i2c_start();
    wr(8'h79, 1'b1, "snap_addr_r");
    for (int k = 0; k < 4; k++) exp_q.push_back(inputs_v[k]);
    exp_q.push_back(model[0]);
    inputs_v = {8'h44, 8'h33, 8'h22, 8'h11};
    rd(1'b1, "snap_in0");
    rd(1'b1, "snap_in1");
    rd(1'b1, "snap_in2");
    rd(1'b1, "snap_in3");
    rd(1'b0, "snap_wrap_reg0");
    i2c_stop();

    // Wrong device address: silent, and the following byte is ignored too.
    commit_ref = commit_cnt;
    i2c_start();
    wr(8'h7A, 1'b0, "badaddr_nack");
    wr(8'h00, 1'b0, "badaddr_silent");
    i2c_stop();
    idle(4);
    check("badaddr_no_commit", 96'(commit_cnt), 96'(commit_ref));
    check("badaddr_outputs", outputs_w, model);

    // Repeated START keeps the write pending; read-back returns the shadow value.
    commit_ref = commit_cnt;
    i2c_start();
    wr(8'h78, 1'b1, "rs_addr_w");
    wr(8'h05, 1'b1, "rs_ptr");
    wr(8'h3C, 1'b1, "rs_data");
    i2c_start();
    wr(8'h78, 1'b1, "rs_addr_w2");
    wr(8'h05, 1'b1, "rs_ptr2");
    i2c_start();
    wr(8'h79, 1'b1, "rs_addr_r");
    exp_q.push_back(8'h3C);
    rd(1'b0, "rs_shadow_read");
    check("rs_no_commit_yet", 96'(commit_cnt), 96'(commit_ref));
    check("rs_outputs_pending", outputs_w, model);
    i2c_stop();
    idle(4);
    model[5] = 8'h3C;
    check("rs_commit_at_stop", 96'(commit_cnt), 96'(commit_ref + 1));
    check("rs_outputs", outputs_w, model);

    // Reset in the middle of a write drops the pending data.
    commit_ref = commit_cnt;
    i2c_start();
    wr(8'h78, 1'b1, "rst_addr");
    wr(8'h01, 1'b1, "rst_ptr");
    wr(8'hEE, 1'b1, "rst_data");
    @(negedge clk);
    rstn = 1'b0;
    idle(5);
    rstn = 1'b1;
    idle(3);
    model = defaults_v;
    check("rst_outputs", outputs_w, model);
    check("rst_busy", {95'b0, busy_w}, 96'd0);
    check("rst_no_commit", 96'(commit_cnt), 96'(commit_ref));
    #(H); sda_m = 1'b1;
    #(H); scl_m = 1'b1;
    #(H);

`ifdef I2C_CFG_SLAVE_GLITCH_FILTER_EN
    // One-clock SDA glitch while SCL is high must not look like START.
    @(negedge clk) sda_m = 1'b0;
    @(negedge clk) sda_m = 1'b1;
    idle(10);
    check("glitch_no_start", {95'b0, busy_w}, 96'd0);
`endif

    // Register 1 reads its default after the aborted write.
    i2c_start();
    wr(8'h78, 1'b1, "post_addr_w");
    wr(8'h01, 1'b1, "post_ptr");
    i2c_start();
    wr(8'h79, 1'b1, "post_addr_r");
    exp_q.push_back(model[1]);
    rd(1'b0, "post_reg1");
    i2c_stop();
    idle(4);
    check("post_busy", {95'b0, busy_w}, 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
